demux4x2_stream: RTL and testbench

- 1-to-4 registered demultiplexer; the inverse of the 4-input, 2-bit-wide mux path.
- Takes one WIDTH-bit word stream with valid/ready and steers each accepted word to one of four output lanes.
- The destination comes from an explicit select or from an internal round-robin pointer.
- Each lane has a one-entry holding register, so downstream backpressure is per lane.
- Sits between a time-multiplexed source and four independent consumers.

---
 rtl/demux4x2_pkg.sv | 20 ++
 rtl/demux_lane_reg.sv | 46 ++++
 rtl/demux4x2_stream.sv | 113 +++++++++++
 tb/tb_demux4x2_stream.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/demux4x2_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
// Counter helpers are used only when DEMUX4X2_STATS_EN is defined.
package demux4x2_pkg;

   localparam int NUM_LANES = 4;
   localparam int SEL_W     = 2;
   localparam int CNT_W     = 8;
   localparam int CNT_MAX   = 255;

   // Saturating increment; holds at CNT_MAX instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      if (v == CNT_W'(CNT_MAX)) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry holding register for a single output lane.
// Data changes only on a load; valid clears on drain without refill.
module demux_lane_reg
   import demux4x2_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             can_accept_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load_i) begin
         data_d  = data_i;
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o       = data_q;
   assign valid_o      = valid_q;
   assign can_accept_o = !valid_q || ready_i;

endmodule

// File: rtl/demux4x2_stream.sv
// Registered 1-to-4 stream demux with explicit or round-robin steering.
// Define DEMUX4X2_STATS_EN to add saturating per-lane transfer counters.
module demux4x2_stream
   import demux4x2_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] I,
   input  logic             I_VALID,
   output logic             I_READY,
   input  logic [1:0]       S,
   input  logic             AUTO,
   output logic [WIDTH-1:0] O0,
   output logic [WIDTH-1:0] O1,
   output logic [WIDTH-1:0] O2,
   output logic [WIDTH-1:0] O3,
   output logic [3:0]       O_VALID,
   input  logic [3:0]       O_READY
`ifdef DEMUX4X2_STATS_EN
   ,
   output logic [7:0]       CNT0,
   output logic [7:0]       CNT1,
   output logic [7:0]       CNT2,
   output logic [7:0]       CNT3
`endif
);

   logic [SEL_W-1:0]     rr_q, rr_d;
   logic [SEL_W-1:0]     dst;
   logic                 accept;
   logic [NUM_LANES-1:0] load;
   logic [NUM_LANES-1:0] can_acc;
   logic [WIDTH-1:0]     lane_data [NUM_LANES];

   assign dst     = AUTO ? rr_q : S;
   assign I_READY = !RESET && can_acc[dst];
   assign accept  = I_VALID && I_READY;

   always_comb begin
      load      = '0;
      load[dst] = accept;
   end

   // Pointer never skips a blocked lane; it only moves on an accept.
   always_comb begin
      rr_d = rr_q;
      if (accept && AUTO) begin
         rr_d = rr_q + SEL_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      demux_lane_reg #(
         .WIDTH (WIDTH)
      ) u_lane (
         .clk_i        (CLK),
         .rst_i        (RESET),
         .load_i       (load[k]),
         .data_i       (I),
         .ready_i      (O_READY[k]),
         .data_o       (lane_data[k]),
         .valid_o      (O_VALID[k]),
         .can_accept_o (can_acc[k])
      );
   end

   assign O0 = lane_data[0];
   assign O1 = lane_data[1];
   assign O2 = lane_data[2];
   assign O3 = lane_data[3];

`ifdef DEMUX4X2_STATS_EN
   logic [CNT_W-1:0] cnt_q [NUM_LANES];
   logic [CNT_W-1:0] cnt_d [NUM_LANES];

   always_comb begin
      for (int k = 0; k < NUM_LANES; k++) begin
         cnt_d[k] = cnt_q[k];
         if (O_VALID[k] && O_READY[k]) begin
            cnt_d[k] = sat_inc(cnt_q[k]);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_LANES; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   assign CNT0 = cnt_q[0];
   assign CNT1 = cnt_q[1];
   assign CNT2 = cnt_q[2];
   assign CNT3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux4x2_stream.sv
// Self-checking bench for demux4x2_stream against a per-lane slot model.
// Counter checks are compiled in when DEMUX4X2_STATS_EN is defined.
module tb_demux4x2_stream;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [1:0] I;
   logic       I_VALID;
   logic       I_READY;
   logic [1:0] S;
   logic       AUTO;
   logic [1:0] O0, O1, O2, O3;
   logic [3:0] O_VALID;
   logic [3:0] O_READY;
`ifdef DEMUX4X2_STATS_EN
   logic [7:0] CNT0, CNT1, CNT2, CNT3;
`endif

   demux4x2_stream #(.WIDTH(2)) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .I       (I),
      .I_VALID (I_VALID),
      .I_READY (I_READY),
      .S       (S),
      .AUTO    (AUTO),
      .O0      (O0),
      .O1      (O1),
      .O2      (O2),
      .O3      (O3),
      .O_VALID (O_VALID),
      .O_READY (O_READY)
`ifdef DEMUX4X2_STATS_EN
      ,
      .CNT0    (CNT0),
      .CNT1    (CNT1),
      .CNT2    (CNT2),
      .CNT3    (CNT3)
`endif
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   // Reference: each lane is a slot that is either empty or holds a word.
   bit   m_full [4];
   int   m_word [4];
   int   m_rr;
   int   m_cnt  [4];

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_full[k] = 0;
         m_word[k] = 0;
         m_cnt[k]  = 0;
      end
      m_rr = 0;
   endtask

   task automatic cyc(input bit rst, input bit iv, input int d,
                      input int s, input bit au, input bit [3:0] ordy);
      int  dest;
      bit  rdy;
      bit  took;
      int  vexp;
      int  outs [4];
      RESET   = rst;
      I_VALID = iv;
      I       = 2'(d);
      S       = 2'(s);
      AUTO    = au;
      O_READY = ordy;
      #1;
      dest = au ? m_rr : s;
      rdy  = !rst && (!m_full[dest] || ordy[dest]);
      chk("i_ready", int'(I_READY), int'(rdy));
      @(posedge CLK);
      if (rst) begin
         model_reset();
      end else begin
         took = iv && rdy;
         for (int k = 0; k < 4; k++) begin
            if (m_full[k] && ordy[k]) begin
               m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
            end
            if (took && dest == k) begin
               m_full[k] = 1;
               m_word[k] = d;
            end else if (m_full[k] && ordy[k]) begin
               m_full[k] = 0;
            end
         end
         if (took && au) begin
            m_rr = (m_rr + 1) % 4;
         end
      end
      #1;
      vexp = 0;
      for (int k = 0; k < 4; k++) begin
         vexp += m_full[k] ? (1 << k) : 0;
      end
      chk("o_valid", int'(O_VALID), vexp);
      outs[0] = int'(O0);
      outs[1] = int'(O1);
      outs[2] = int'(O2);
      outs[3] = int'(O3);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("o%0d", k), outs[k], m_word[k]);
      end
`ifdef DEMUX4X2_STATS_EN
      chk("cnt0", int'(CNT0), m_cnt[0]);
      chk("cnt1", int'(CNT1), m_cnt[1]);
      chk("cnt2", int'(CNT2), m_cnt[2]);
      chk("cnt3", int'(CNT3), m_cnt[3]);
`endif
   endtask

   initial begin
      RESET   = 1'b1;
      I       = 2'd0;
      I_VALID = 1'b0;
      S       = 2'd0;
      AUTO    = 1'b0;
      O_READY = 4'b0000;
      model_reset();
      @(posedge CLK);
      #1;

      // Reset held with a valid word offered.
      cyc(1, 1, 3, 0, 0, 4'b1111);
      cyc(1, 1, 3, 0, 0, 4'b1111);
      chk("rst_valid", int'(O_VALID), 0);
      chk("rst_o0", int'(O0), 0);

      // Explicit select.
      cyc(0, 1, 1, 2, 0, 4'b1111);
      chk("sel_v2", int'(O_VALID[2]), 1);
      chk("sel_o2", int'(O2), 1);
      cyc(0, 1, 3, 0, 0, 4'b1111);
      chk("sel_o0", int'(O0), 3);

      // Round-robin wrap: lanes 0,1,2,3,0 then pointer at 1.
      for (int w = 0; w < 5; w++) begin
         cyc(0, 1, w % 4, 0, 1, 4'b1111);
         chk("rr_lane", int'(O_VALID), 1 << (w % 4));
      end
      cyc(0, 1, 2, 0, 1, 4'b1111);
      chk("rr_after", int'(O_VALID), 4'b0010);
      chk("rr_o1", int'(O1), 2);
      cyc(0, 0, 0, 0, 0, 4'b1111);

      // Backpressure on lane 1, then a free lane still accepts.
      cyc(0, 1, 2, 1, 0, 4'b1101);
      cyc(0, 1, 3, 1, 0, 4'b1101);
      chk("bp_ready", int'(I_READY), 0);
      chk("bp_o1", int'(O1), 2);
      cyc(0, 1, 1, 3, 0, 4'b0101);
      chk("bp_o3", int'(O3), 1);
      chk("bp_v", int'(O_VALID), 4'b1010);

      // Same-cycle drain and refill of lane 1.
      cyc(0, 1, 1, 1, 0, 4'b1111);
      chk("df_o1", int'(O1), 1);
      chk("df_v1", int'(O_VALID[1]), 1);

      // Randomized traffic with occasional mid-run resets.
      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 39) == 0),
             1'($urandom),
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)),
             1'($urandom),
             4'($urandom));
      end

`ifdef DEMUX4X2_STATS_EN
      cyc(1, 0, 0, 0, 0, 4'b0000);
      for (int n = 0; n < 262; n++) begin
         cyc(0, 1, n % 4, 0, 0, 4'b0001);
      end
      chk("cnt0_sat", int'(CNT0), 255);
      cyc(1, 0, 0, 0, 0, 4'b0000);
      chk("cnt0_clr", int'(CNT0), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
